// File: rtl/set_assoc_cache_pkg.sv
// Shared types and width helpers for the set-associative cache.
// The helpers keep the address split consistent between top and bench.
package set_assoc_cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MEM_RD,
    MEM_WAIT,
    MEM_WR,
    RESP
  } state_e;

  function automatic int set_width(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tag_width(input int addr_width, input int num_sets);
    return addr_width - $clog2(num_sets) - 2;
  endfunction

endpackage

// File: rtl/set_assoc_cache_victim_select.sv
// Replacement choice for one set: the lowest invalid way wins, otherwise
// the round-robin pointer way. Purely combinational.
module cache_victim_select #(
  parameter int NUM_WAYS = 4
) (
  input  logic [NUM_WAYS-1:0]         valid_vec,
  input  logic [$clog2(NUM_WAYS)-1:0] ptr,
  output logic [$clog2(NUM_WAYS)-1:0] victim_way,
  output logic                        full
);

  localparam int WAY_W = $clog2(NUM_WAYS);

  always_comb begin
    victim_way = ptr;
    full       = &valid_vec;
    // Scan downwards so the lowest invalid index is the last one written.
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_vec[w]) victim_way = WAY_W'(w);
    end
  end

endmodule

// File: rtl/set_assoc_cache.sv
// N-way set-associative write-through, write-allocate cache, one word per
// line, with request/response handshakes and a single-outstanding memory port.
module set_assoc_cache
  import set_assoc_cache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_SETS   = 8,
  parameter int NUM_WAYS   = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  aresetn_i,
  input  logic                  flush_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_hit_o,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [CNT_WIDTH-1:0]  hit_cnt_o,
  output logic [CNT_WIDTH-1:0]  miss_cnt_o
);

  localparam int SET_W = set_width(NUM_SETS);
  localparam int TAG_W = tag_width(ADDR_WIDTH, NUM_SETS);
  localparam int WAY_W = $clog2(NUM_WAYS);

  state_e                 state_reg;
  logic [ADDR_WIDTH-1:2]  addr_reg;
  logic                   we_reg;
  logic [DATA_WIDTH-1:0]  wdata_reg;
  logic [WAY_W-1:0]       victim_reg;
  logic                   bump_reg;

  logic [NUM_WAYS-1:0]    valid_reg [NUM_SETS];
  logic [WAY_W-1:0]       ptr_reg   [NUM_SETS];

  logic                   accept;
  logic [SET_W-1:0]       req_set;
  logic [SET_W-1:0]       set_cur;
  logic [TAG_W-1:0]       tag_cur;
  logic [NUM_WAYS-1:0]    hit_vec;
  logic                   hit;
  logic [WAY_W-1:0]       hit_way;
  logic [DATA_WIDTH-1:0]  hit_data;
  logic [DATA_WIDTH-1:0]  data_rd [NUM_WAYS];
  logic [WAY_W-1:0]       victim_way;
  logic                   set_full;

  logic                   install_en;
  logic [WAY_W-1:0]       install_way;
  logic                   install_bump;
  logic [DATA_WIDTH-1:0]  install_data;

  logic                   unused_byte_offset;
  assign unused_byte_offset = ^req_addr_i[1:0];

  assign req_ready_o = (state_reg == IDLE) && !flush_i;
  assign accept      = req_valid_i && req_ready_o;
  assign req_set     = req_addr_i[SET_W+1:2];
  assign set_cur     = addr_reg[SET_W+1:2];
  assign tag_cur     = addr_reg[ADDR_WIDTH-1:SET_W+2];

  cache_victim_select #(
    .NUM_WAYS(NUM_WAYS)
  ) u_victim (
    .valid_vec (valid_reg[set_cur]),
    .ptr       (ptr_reg[set_cur]),
    .victim_way(victim_way),
    .full      (set_full)
  );

  // Tag/data storage per way; read at acceptance so LOOKUP sees registered data.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_WAYS; gi++) begin : g_way
      logic [TAG_W-1:0]      tag_mem  [NUM_SETS];
      logic [DATA_WIDTH-1:0] data_mem [NUM_SETS];
      logic [TAG_W-1:0]      tag_rd_reg;
      logic [DATA_WIDTH-1:0] data_rd_reg;

      always_ff @(posedge clk_i) begin
        if (install_en && install_way == WAY_W'(gi)) begin
          tag_mem[set_cur]  <= tag_cur;
          data_mem[set_cur] <= install_data;
        end
        if (accept) begin
          tag_rd_reg  <= tag_mem[req_set];
          data_rd_reg <= data_mem[req_set];
        end
      end

      assign data_rd[gi] = data_rd_reg;
      assign hit_vec[gi] = valid_reg[set_cur][gi] && (tag_rd_reg == tag_cur);
    end
  endgenerate

  assign hit = |hit_vec;

  always_comb begin
    hit_way  = '0;
    hit_data = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (hit_vec[w]) begin
        hit_way  = WAY_W'(w);
        hit_data = data_rd[w];
      end
    end
  end

  // Writes allocate during LOOKUP; read misses install when memory answers.
  always_comb begin
    install_en   = 1'b0;
    install_way  = victim_way;
    install_bump = 1'b0;
    install_data = wdata_reg;
    if (state_reg == LOOKUP && we_reg) begin
      install_en   = 1'b1;
      install_way  = hit ? hit_way : victim_way;
      install_bump = !hit && set_full;
    end else if (state_reg == MEM_WAIT && mem_rvalid_i) begin
      install_en   = 1'b1;
      install_way  = victim_reg;
      install_bump = bump_reg;
      install_data = mem_rdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_reg[s] <= '0;
        ptr_reg[s]   <= '0;
      end
    end else if (state_reg == IDLE && flush_i) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_reg[s] <= '0;
        ptr_reg[s]   <= '0;
      end
    end else if (install_en) begin
      valid_reg[set_cur][install_way] <= 1'b1;
      if (install_bump) ptr_reg[set_cur] <= ptr_reg[set_cur] + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state_reg       <= IDLE;
      addr_reg        <= '0;
      we_reg          <= 1'b0;
      wdata_reg       <= '0;
      victim_reg      <= '0;
      bump_reg        <= 1'b0;
      resp_valid_o    <= 1'b0;
      resp_rdata_o    <= '0;
      resp_hit_o      <= 1'b0;
      mem_req_valid_o <= 1'b0;
      mem_we_o        <= 1'b0;
      mem_addr_o      <= '0;
      mem_wdata_o     <= '0;
      hit_cnt_o       <= '0;
      miss_cnt_o      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            addr_reg  <= req_addr_i[ADDR_WIDTH-1:2];
            we_reg    <= req_we_i;
            wdata_reg <= req_wdata_i;
            state_reg <= LOOKUP;
          end
        end
        LOOKUP: begin
          victim_reg <= victim_way;
          bump_reg   <= set_full;
          resp_hit_o <= hit;
          if (hit) begin
            if (hit_cnt_o != '1) hit_cnt_o <= hit_cnt_o + 1'b1;
          end else begin
            if (miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + 1'b1;
          end
          if (we_reg) begin
            mem_req_valid_o <= 1'b1;
            mem_we_o        <= 1'b1;
            mem_addr_o      <= {addr_reg, 2'b00};
            mem_wdata_o     <= wdata_reg;
            state_reg       <= MEM_WR;
          end else if (hit) begin
            resp_valid_o <= 1'b1;
            resp_rdata_o <= hit_data;
            state_reg    <= RESP;
          end else begin
            mem_req_valid_o <= 1'b1;
            mem_we_o        <= 1'b0;
            mem_addr_o      <= {addr_reg, 2'b00};
            mem_wdata_o     <= '0;
            state_reg       <= MEM_RD;
          end
        end
        MEM_RD: begin
          if (mem_req_ready_i) begin
            mem_req_valid_o <= 1'b0;
            state_reg       <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (mem_rvalid_i) begin
            resp_valid_o <= 1'b1;
            resp_rdata_o <= mem_rdata_i;
            state_reg    <= RESP;
          end
        end
        MEM_WR: begin
          if (mem_req_ready_i) begin
            mem_req_valid_o <= 1'b0;
            mem_we_o        <= 1'b0;
            resp_valid_o    <= 1'b1;
            resp_rdata_o    <= '0;
            state_reg       <= RESP;
          end
        end
        RESP: begin
          if (resp_ready_i) begin
            resp_valid_o <= 1'b0;
            state_reg    <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
